// File: rtl/mult_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared constants and types for the mult_arbiter bus-master
//                sequencer: peripheral register map, FSM state encoding and
//                poll-counter sizing.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    // Peripheral register map (byte addresses on the 5-bit bus)
    localparam logic [4:0] ADDR_A      = 5'h04;
    localparam logic [4:0] ADDR_B      = 5'h08;
    localparam logic [4:0] ADDR_INIT   = 5'h0C;
    localparam logic [4:0] ADDR_DONE   = 5'h10;
    localparam logic [4:0] ADDR_RESULT = 5'h14;

    // Default number of done-polls before an operation is abandoned
    localparam int DEFAULT_TIMEOUT = 64;

    // Poll counter must be able to hold the value TIMEOUT itself
    function automatic int poll_cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int POLL_CNT_W = poll_cnt_width(DEFAULT_TIMEOUT);

    // Sequencer states, in bus-sequence order
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_A     = 4'd1,
        ST_WR_B     = 4'd2,
        ST_INIT_SET = 4'd3,
        ST_INIT_CLR = 4'd4,
        ST_POLL_RD  = 4'd5,
        ST_POLL_CHK = 4'd6,
        ST_RES_RD   = 4'd7,
        ST_RES_CHK  = 4'd8,
        ST_ACK      = 4'd9,
        ST_GAP      = 4'd10
    } state_e;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin arbiter. Grant is combinational from the
//                request vector and the priority pointer; the pointer moves to
//                the requester that was not just served when advance is high.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,        // asynchronous, active-low
    input  logic [1:0] req,
    input  logic       advance,    // one-cycle pulse when a service completes
    input  logic       served,     // index of the requester just served
    output logic       gnt_valid,
    output logic       gnt_idx
);

    logic ptr_q;
    logic ptr_d;

    // Requester at the pointer wins; otherwise the other one if it asks
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = 1'b0;
        if (req[ptr_q]) begin
            gnt_idx = ptr_q;
        end else if (req[~ptr_q]) begin
            gnt_idx = ~ptr_q;
        end
    end

    // After a completion, priority passes to the other requester
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = ~served;
        end
    end

    // Priority pointer register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mult_arbiter
//  Description : Shares one multiplier peripheral between two requesters.
//                Arbitrates round-robin, then runs the register sequence
//                write A / write B / init pulse / poll done / read result and
//                returns the 32-bit product with a one-cycle ack.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,        // asynchronous, active-low
    input  logic [1:0]  req,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    output logic [1:0]  ack,
    output logic [31:0] result,
    output logic        err,
    output logic        busy,
    output logic        m_cs,
    output logic        m_rd,
    output logic        m_wr,
    output logic [4:0]  m_addr,
    output logic [15:0] m_dout,
    input  logic [31:0] m_din
);

    localparam int               CNT_W       = poll_cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    // FSM state
    state_e state_q, state_d;

    // Datapath registers
    logic             gnt_q,    gnt_d;
    logic [15:0]      a_q,      a_d;
    logic [15:0]      b_q,      b_d;
    logic [CNT_W-1:0] poll_q,   poll_d;
    logic [31:0]      result_q, result_d;
    logic             err_q,    err_d;

    // Registered outputs
    logic [1:0]       ack_q,    ack_d;
    logic             busy_q,   busy_d;
    logic             m_cs_q,   m_cs_d;
    logic             m_rd_q,   m_rd_d;
    logic             m_wr_q,   m_wr_d;
    logic [4:0]       m_addr_q, m_addr_d;
    logic [15:0]      m_dout_q, m_dout_d;

    // Arbiter interface
    logic w_gnt_valid;
    logic w_gnt_idx;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .advance   (state_q == ST_ACK),
        .served    (gnt_q),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    // Next-state logic: fixed bus sequence with a done-poll loop
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (w_gnt_valid) state_d = ST_WR_A;
            ST_WR_A:     state_d = ST_WR_B;
            ST_WR_B:     state_d = ST_INIT_SET;
            ST_INIT_SET: state_d = ST_INIT_CLR;
            ST_INIT_CLR: state_d = ST_POLL_RD;
            ST_POLL_RD:  state_d = ST_POLL_CHK;
            ST_POLL_CHK: begin
                if (m_din[0]) begin
                    state_d = ST_RES_RD;
                end else if (poll_q < TIMEOUT_CNT) begin
                    state_d = ST_POLL_RD;
                end else begin
                    state_d = ST_ACK;
                end
            end
            ST_RES_RD:   state_d = ST_RES_CHK;
            ST_RES_CHK:  state_d = ST_ACK;
            ST_ACK:      state_d = ST_GAP;
            ST_GAP:      state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Operand latch, poll counter and result/err capture
    always_comb begin
        gnt_d    = gnt_q;
        a_d      = a_q;
        b_d      = b_q;
        poll_d   = poll_q;
        result_d = result_q;
        err_d    = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (w_gnt_valid) begin
                    gnt_d  = w_gnt_idx;
                    a_d    = w_gnt_idx ? a1 : a0;
                    b_d    = w_gnt_idx ? b1 : b0;
                    poll_d = '0;
                end
            end
            ST_POLL_RD: begin
                poll_d = poll_q + CNT_ONE;
            end
            ST_POLL_CHK: begin
                // Timed out: report error with a zero product
                if (state_d == ST_ACK) begin
                    result_d = '0;
                    err_d    = 1'b1;
                end
            end
            ST_RES_CHK: begin
                result_d = m_din;
                err_d    = 1'b0;
            end
            default: ;
        endcase
    end

    // Output decode from the next state so every strobe is a flop output
    always_comb begin
        ack_d    = 2'b00;
        busy_d   = (state_d != ST_IDLE);
        m_cs_d   = 1'b0;
        m_rd_d   = 1'b0;
        m_wr_d   = 1'b0;
        m_addr_d = 5'h00;
        m_dout_d = 16'h0000;
        unique case (state_d)
            ST_WR_A: begin
                m_cs_d   = 1'b1;
                m_wr_d   = 1'b1;
                m_addr_d = ADDR_A;
                m_dout_d = a_d;
            end
            ST_WR_B: begin
                m_cs_d   = 1'b1;
                m_wr_d   = 1'b1;
                m_addr_d = ADDR_B;
                m_dout_d = b_d;
            end
            ST_INIT_SET: begin
                m_cs_d   = 1'b1;
                m_wr_d   = 1'b1;
                m_addr_d = ADDR_INIT;
                m_dout_d = 16'h0001;
            end
            ST_INIT_CLR: begin
                m_cs_d   = 1'b1;
                m_wr_d   = 1'b1;
                m_addr_d = ADDR_INIT;
                m_dout_d = 16'h0000;
            end
            ST_POLL_RD: begin
                m_cs_d   = 1'b1;
                m_rd_d   = 1'b1;
                m_addr_d = ADDR_DONE;
            end
            ST_RES_RD: begin
                m_cs_d   = 1'b1;
                m_rd_d   = 1'b1;
                m_addr_d = ADDR_RESULT;
            end
            ST_ACK: begin
                ack_d = gnt_d ? 2'b10 : 2'b01;
            end
            default: ;
        endcase
    end

    // State, datapath and output registers; reset abandons any transfer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= 1'b0;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            poll_q   <= '0;
            result_q <= 32'h0000_0000;
            err_q    <= 1'b0;
            ack_q    <= 2'b00;
            busy_q   <= 1'b0;
            m_cs_q   <= 1'b0;
            m_rd_q   <= 1'b0;
            m_wr_q   <= 1'b0;
            m_addr_q <= 5'h00;
            m_dout_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            poll_q   <= poll_d;
            result_q <= result_d;
            err_q    <= err_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            m_cs_q   <= m_cs_d;
            m_rd_q   <= m_rd_d;
            m_wr_q   <= m_wr_d;
            m_addr_q <= m_addr_d;
            m_dout_q <= m_dout_d;
        end
    end

    assign ack    = ack_q;
    assign result = result_q;
    assign err    = err_q;
    assign busy   = busy_q;
    assign m_cs   = m_cs_q;
    assign m_rd   = m_rd_q;
    assign m_wr   = m_wr_q;
    assign m_addr = m_addr_q;
    assign m_dout = m_dout_q;

endmodule : mult_arbiter
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_arbiter
//  Description : Scoreboard bench for mult_arbiter with a behavioural model of
//                the multiplier peripheral register interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0]  ack;
    logic [31:0] result;
    logic        err, busy, m_cs, m_rd, m_wr;
    logic [4:0]  m_addr;
    logic [15:0] m_dout;
    logic [31:0] m_din = '0;

    mult_arbiter #(.TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .req(req),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack(ack), .result(result), .err(err), .busy(busy),
        .m_cs(m_cs), .m_rd(m_rd), .m_wr(m_wr),
        .m_addr(m_addr), .m_dout(m_dout), .m_din(m_din)
    );

    always #5 clk = ~clk;

    // Posedge counter; stable at negedges where everything is sampled
    int pcyc = 0;
    always @(posedge clk) pcyc <= pcyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: got no event within bound, required event", name);
    endtask

    // ---------------- peripheral model ----------------
    typedef struct { logic [4:0] addr; logic [15:0] data; } wr_t;
    wr_t         wlog[$];
    logic [15:0] pa = '0, pb = '0;
    int          polls = 0, done_after = 1, poll_reads = 0, res_reads = 0;
    int          pn;

    always @(posedge clk) begin
        if (m_cs && m_wr) begin
            wlog.push_back('{m_addr, m_dout});
            if (m_addr == 5'h04) pa <= m_dout;
            if (m_addr == 5'h08) pb <= m_dout;
            if (m_addr == 5'h0C && m_dout[0]) polls <= 0;
        end
        if (m_cs && m_rd) begin
            if (m_addr == 5'h10) begin
                pn = polls + 1;
                polls <= pn;
                poll_reads <= poll_reads + 1;
                m_din <= {31'b0, (done_after != 0 && pn >= done_after)};
            end else if (m_addr == 5'h14) begin
                res_reads <= res_reads + 1;
                m_din <= {16'h0, pa} * {16'h0, pb};
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct { int idx; logic [31:0] res; logic err; int cyc; } exp_t;
    exp_t sb[$];

    task automatic expect_ack(input int idx, input logic [31:0] r, input logic e, input int c);
        sb.push_back('{idx, r, e, c});
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ack != 2'b00) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {30'b0, ack}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("ack_idx", {30'b0, ack}, (e.idx == 1) ? 32'h2 : 32'h1);
                chk("ack_result", result, e.res);
                chk("ack_err", {31'b0, err}, {31'b0, e.err});
                if (e.cyc >= 0) chk("ack_cycle", pcyc, e.cyc);
            end
        end
    end

    task automatic wait_ack(input int idx);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (ack[idx]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now($sformatf("ack%0d_timeout", idx));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w0, pr0, rr0;
        bit seen;

        repeat (3) @(negedge clk);
        chk("rst_busy_during", {31'b0, busy}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ack", {30'b0, ack}, 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_strobes", {29'b0, m_cs, m_rd, m_wr}, 32'h0);
        chk("rst_addr_dout", {11'b0, m_addr, m_dout}, 32'h0);

        // Single request, done on first poll; operands changed after grant
        w0 = wlog.size(); pr0 = poll_reads; rr0 = res_reads;
        a0 = 16'h0005; b0 = 16'h000F;
        expect_ack(0, 32'h0000_004B, 1'b0, pcyc + 9);
        req = 2'b01;
        @(negedge clk);
        chk("busy_active", {31'b0, busy}, 32'h1);
        a0 = 16'hDEAD; b0 = 16'hBEEF;
        wait_ack(0);
        req = 2'b00;
        if (wlog.size() >= w0 + 4) begin
            chk("wr0", {11'b0, wlog[w0].addr,   wlog[w0].data},   {11'b0, 5'h04, 16'h0005});
            chk("wr1", {11'b0, wlog[w0+1].addr, wlog[w0+1].data}, {11'b0, 5'h08, 16'h000F});
            chk("wr2", {11'b0, wlog[w0+2].addr, wlog[w0+2].data}, {11'b0, 5'h0C, 16'h0001});
            chk("wr3", {11'b0, wlog[w0+3].addr, wlog[w0+3].data}, {11'b0, 5'h0C, 16'h0000});
        end else begin
            fail_now("write_trace_short");
        end
        chk("single_polls", poll_reads - pr0, 32'd1);
        chk("single_res_reads", res_reads - rr0, 32'd1);
        repeat (3) @(negedge clk);

        // Simultaneous requests straight out of reset
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        a0 = 16'd3; b0 = 16'd4; a1 = 16'hFFFF; b1 = 16'hFFFF;
        expect_ack(0, 32'd12, 1'b0, -1);
        expect_ack(1, 32'hFFFE_0001, 1'b0, -1);
        req = 2'b11;
        wait_ack(0);
        req[0] = 1'b0;
        wait_ack(1);
        req = 2'b00;
        repeat (3) @(negedge clk);

        // Fairness: both held for six operations
        a0 = 16'd7; b0 = 16'd9; a1 = 16'h1234; b1 = 16'h0010;
        for (int k = 0; k < 6; k++)
            expect_ack(k % 2, (k % 2) ? 32'h0001_2340 : 32'd63, 1'b0, -1);
        req = 2'b11;
        for (int k = 0; k < 6; k++) wait_ack(k % 2);
        req = 2'b00;
        repeat (3) @(negedge clk);

        // Timeout: done never set
        done_after = 0;
        pr0 = poll_reads; rr0 = res_reads;
        a0 = 16'd2; b0 = 16'd3;
        expect_ack(0, 32'h0, 1'b1, -1);
        req = 2'b01;
        wait_ack(0);
        req = 2'b00;
        chk("timeout_polls", poll_reads - pr0, 32'd64);
        chk("timeout_res_reads", res_reads - rr0, 32'd0);
        done_after = 1;
        repeat (3) @(negedge clk);

        // Slow done on third poll: four cycles later than the immediate case
        done_after = 3;
        a0 = 16'h0100; b0 = 16'h0100;
        expect_ack(0, 32'h0001_0000, 1'b0, pcyc + 13);
        req = 2'b01;
        wait_ack(0);
        req = 2'b00;
        done_after = 1;
        repeat (3) @(negedge clk);

        // Reset during POLL_CHK; pointer currently favours requester 1
        a0 = 16'd1; b0 = 16'd1;
        req = 2'b01;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_rd && m_addr == 5'h10) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now("poll_strobe");
        @(negedge clk);
        chk("busy_in_poll_chk", {31'b0, busy}, 32'h1);
        #1 rst = 1'b0;
        #1;
        chk("async_strobes", {29'b0, m_cs, m_rd, m_wr}, 32'h0);
        chk("async_busy", {31'b0, busy}, 32'h0);
        req = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_rst_busy", {31'b0, busy}, 32'h0);
        a0 = 16'd6; b0 = 16'd7; a1 = 16'd2; b1 = 16'd2;
        expect_ack(0, 32'd42, 1'b0, -1);
        expect_ack(1, 32'd4, 1'b0, -1);
        req = 2'b11;
        wait_ack(0);
        req[0] = 1'b0;
        wait_ack(1);
        req = 2'b00;

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_mult_arbiter
`default_nettype wire
